// File: rtl/div_result_checker_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_result_checker_seq : checks a divider result by shift-add q*d + r == dividend
// Revision: 1.0
// ---------------------------------------------------------------------------
module div_result_checker_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     quotient,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     remainder,
  input  logic [WIDTH-1:0]     dividend,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 match,
  output logic                 err_range
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADD  = 2'd2,
    CMP  = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     div_r;
  logic [WIDTH-1:0]     rem_r;
  logic [WIDTH-1:0]     dvd_r;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic                 err_next;

  // Range check uses the latched operands so live input changes cannot leak in.
  assign err_next = (div_r == '0) || (rem_r >= div_r);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      div_r     <= '0;
      rem_r     <= '0;
      dvd_r     <= '0;
      acc       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      product   <= '0;
      match     <= 1'b0;
      err_range <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mplier <= quotient;
            mcand  <= {{WIDTH{1'b0}}, divisor};
            div_r  <= divisor;
            rem_r  <= remainder;
            dvd_r  <= dividend;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state <= ADD;
          end
        end
        ADD: begin
          acc   <= acc + {{WIDTH{1'b0}}, rem_r};
          state <= CMP;
        end
        CMP: begin
          product   <= acc;
          err_range <= err_next;
          match     <= (acc == {{WIDTH{1'b0}}, dvd_r}) && !err_next;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_result_checker_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_div_result_checker_seq : randomized self-checking bench for div_result_checker_seq
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_div_result_checker_seq;

  localparam int W = 16;
  localparam int LAT = W + 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   quotient, divisor, remainder, dividend;
  logic           busy, done, match, err_range;
  logic [2*W-1:0] product;

  int tests = 0;
  int fails = 0;

  div_result_checker_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .quotient(quotient), .divisor(divisor), .remainder(remainder), .dividend(dividend),
    .busy(busy), .done(done), .product(product), .match(match), .err_range(err_range)
  );

  always #5 clk = ~clk;

  // Reference: {match, err_range, product} from plain integer arithmetic.
  function automatic logic [2*W+1:0] model(input logic [W-1:0] q, d, r, dv);
    longint unsigned p;
    logic e, m;
    p = longint'(q) * longint'(d) + longint'(r);
    e = (d == 0) || (r >= d);
    m = (p == longint'(dv)) && !e;
    return {m, e, p[2*W-1:0]};
  endfunction

  // Presents operands with start for one edge, then scrambles the live inputs.
  task automatic launch(input logic [W-1:0] q, d, r, dv);
    quotient = q; divisor = d; remainder = r; dividend = dv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    quotient = W'($urandom); divisor = W'($urandom);
    remainder = W'($urandom); dividend = W'($urandom);
  endtask

  // Waits (bounded) for done; lat is edges after the start edge, -1 on timeout.
  task automatic wait_done(input int j0, output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = busy ? 1 : 0;
    for (int j = j0 + 1; j <= j0 + 40; j++) begin
      @(negedge clk);
      if (done) begin
        lat = j;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0;
    quotient = '0; divisor = '0; remainder = '0; dividend = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, done, match, err_range} !== 4'b0 || product !== '0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b match=%b err=%b product=%h, required all zero",
               busy, done, match, err_range, product);
    end
    quotient = 16'd14; divisor = 16'd7; remainder = 16'd2; dividend = 16'd100;
    begin
      int act = 0;
      repeat (10) begin
        @(negedge clk);
        if (busy || done) act++;
      end
      tests++;
      if (act !== 0) begin
        fails++;
        $display("FAIL idle_no_start: %0d active cycles, required 0", act);
      end
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    launch(16'd14, 16'd7, 16'd2, 16'd100);
    wait_done(0, lat, bc);
    tests++;
    if (lat !== LAT) begin
      fails++;
      $display("FAIL basic_latency: got %0d, required %0d", lat, LAT);
    end
    tests++;
    if (bc !== LAT || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy: busy cycles %0d busy_at_done=%b, required %0d and 0", bc, busy, LAT);
    end
    tests++;
    if ({match, err_range, product} !== {1'b1, 1'b0, 32'd100}) begin
      fails++;
      $display("FAIL basic_result: match=%b err=%b product=%0d, required 1 0 100", match, err_range, product);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || product !== 32'd100 || match !== 1'b1) begin
      fails++;
      $display("FAIL basic_hold: done=%b product=%0d match=%b, required 0 100 1", done, product, match);
    end
  endtask

  task automatic test_mismatch();
    int lat, bc;
    launch(16'd14, 16'd7, 16'd3, 16'd100);
    wait_done(0, lat, bc);
    tests++;
    if (lat !== LAT || {match, err_range, product} !== {1'b0, 1'b0, 32'd101}) begin
      fails++;
      $display("FAIL mismatch_r3: lat=%0d match=%b err=%b product=%0d, required %0d 0 0 101",
               lat, match, err_range, product, LAT);
    end
    launch(16'd14, 16'd7, 16'd7, 16'd105);
    wait_done(0, lat, bc);
    tests++;
    if (lat !== LAT || {match, err_range, product} !== {1'b0, 1'b1, 32'd105}) begin
      fails++;
      $display("FAIL rem_eq_div: lat=%0d match=%b err=%b product=%0d, required %0d 0 1 105",
               lat, match, err_range, product, LAT);
    end
  endtask

  task automatic test_boundaries();
    int lat, bc;
    launch(16'hFFFF, 16'd0, 16'd5, 16'd5);
    wait_done(0, lat, bc);
    tests++;
    if (lat !== LAT || {match, err_range, product} !== {1'b0, 1'b1, 32'd5}) begin
      fails++;
      $display("FAIL div_zero: lat=%0d match=%b err=%b product=%h, required %0d 0 1 5",
               lat, match, err_range, product, LAT);
    end
    launch(16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF);
    wait_done(0, lat, bc);
    tests++;
    if (lat !== LAT || {match, err_range, product} !== {1'b0, 1'b0, 32'hFFFE_FFFF}) begin
      fails++;
      $display("FAIL max_operands: lat=%0d match=%b err=%b product=%h, required %0d 0 0 fffeffff",
               lat, match, err_range, product, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, extra;
    // A start pulse during CALC must be ignored.
    launch(16'd20, 16'd5, 16'd3, 16'd103);
    repeat (3) @(negedge clk);
    quotient = 16'd1; divisor = 16'd1; remainder = 16'd0; dividend = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, lat, bc);
    tests++;
    if (lat !== LAT || {match, err_range, product} !== {1'b1, 1'b0, 32'd103}) begin
      fails++;
      $display("FAIL ignore_start: lat=%0d match=%b err=%b product=%0d, required %0d 1 0 103",
               lat, match, err_range, product, LAT);
    end
    // New start in the done cycle begins immediately.
    launch(16'd9, 16'd11, 16'd4, 16'd103);
    wait_done(0, lat, bc);
    tests++;
    if (lat !== LAT || {match, err_range, product} !== {1'b1, 1'b0, 32'd103}) begin
      fails++;
      $display("FAIL back_to_back: lat=%0d match=%b err=%b product=%0d, required %0d 1 0 103",
               lat, match, err_range, product, LAT);
    end
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL spurious_done: %0d extra done pulses, required 0", extra);
    end
  endtask

  task automatic test_abort();
    int lat, bc, seen;
    launch(16'd100, 16'd200, 16'd7, 16'd1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, match, err_range} !== 4'b0 || product !== '0) begin
      fails++;
      $display("FAIL abort_reset: busy=%b done=%b match=%b err=%b product=%h, required all zero",
               busy, done, match, err_range, product);
    end
    rst = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL abort_no_done: %0d active cycles after abort, required 0", seen);
    end
    launch(16'd3, 16'd5, 16'd1, 16'd16);
    wait_done(0, lat, bc);
    tests++;
    if (lat !== LAT || {match, err_range, product} !== {1'b1, 1'b0, 32'd16}) begin
      fails++;
      $display("FAIL after_abort: lat=%0d match=%b err=%b product=%0d, required %0d 1 0 16",
               lat, match, err_range, product, LAT);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [W-1:0] q, d, r, dv;
    logic [2*W+1:0] exp;
    for (int i = 0; i < 40; i++) begin
      dv = W'($urandom);
      d  = W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom);
      if (d != 0) begin
        q = dv / d;
        r = dv % d;
      end else begin
        q = W'($urandom);
        r = W'($urandom);
      end
      case ($urandom_range(0, 3))
        0: r = r + W'($urandom_range(1, 3));
        1: q = W'($urandom);
        2: r = W'($urandom);
        default: ;
      endcase
      exp = model(q, d, r, dv);
      launch(q, d, r, dv);
      wait_done(0, lat, bc);
      tests++;
      if (lat !== LAT || {match, err_range, product} !== exp) begin
        fails++;
        $display("FAIL random_%0d: q=%h d=%h r=%h dv=%h lat=%0d got m=%b e=%b p=%h, required lat=%0d m=%b e=%b p=%h",
                 i, q, d, r, dv, lat, match, err_range, product, LAT, exp[2*W+1], exp[2*W], exp[2*W-1:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_mismatch();
    test_boundaries();
    test_back_to_back();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
